// File: rtl/shift_seq_counter_if.sv
// Control/status bundle for shift_seq_counter: step/load controls in, state and pulses out.
// master drives controls (the counter's user); slave is the counter itself.
interface shift_seq_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic [1:0]       mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             wrap;
  logic             lock_err;

  modport master (
    output en, mode, dir, load, load_val,
    input  q, q_n, wrap, lock_err
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output q, q_n, wrap, lock_err
  );
endinterface

// File: rtl/shift_seq_counter.sv
// Ring / Johnson / LFSR shift counter with parallel load; q, wrap, lock_err update one clock after en/load/reset.
// No backpressure: a step is taken on every edge with en high, load and reset take precedence.
module shift_seq_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(3)
) (
  input  logic               clk,
  input  logic               reset,
  shift_seq_counter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_RING    = 2'b00,
    MODE_JOHNSON = 2'b01,
    MODE_LFSR    = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             lock_r;
  logic [WIDTH-1:0] step_q;
  logic             fb;
  logic             lfsr_stuck;
  mode_e            mode;

  assign mode       = mode_e'(bus.mode);
  assign fb         = ^(q_r & TAPS);
  assign lfsr_stuck = (mode == MODE_LFSR) && (q_r == '0);

  always_comb begin
    step_q = q_r;
    case (mode)
      MODE_RING:
        step_q = bus.dir ? {q_r[WIDTH-2:0], q_r[WIDTH-1]}
                         : {q_r[0], q_r[WIDTH-1:1]};
      MODE_JOHNSON:
        step_q = bus.dir ? {q_r[WIDTH-2:0], ~q_r[WIDTH-1]}
                         : {~q_r[0], q_r[WIDTH-1:1]};
      MODE_LFSR:
        step_q = {fb, q_r[WIDTH-1:1]};
      default:
        step_q = q_r;
    endcase
  end

  // All-zero LFSR state is a fixed point; recover to SEED instead of stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= SEED;
      wrap_r <= 1'b0;
      lock_r <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      lock_r <= 1'b0;
      if (bus.load) begin
        q_r <= bus.load_val;
      end else if (bus.en) begin
        if (lfsr_stuck) begin
          q_r    <= SEED;
          lock_r <= 1'b1;
        end else if (mode != MODE_HOLD) begin
          q_r    <= step_q;
          wrap_r <= (step_q == SEED);
        end
      end
    end
  end

  assign bus.q        = q_r;
  assign bus.q_n      = ~q_r;
  assign bus.wrap     = wrap_r;
  assign bus.lock_err = lock_r;

endmodule

// File: tb/tb_shift_seq_counter.sv
// Randomized and directed stimulus for shift_seq_counter, checked by a queue-based scoreboard.
module tb_shift_seq_counter;
  localparam int       W    = 4;
  localparam bit [3:0] SEED = 4'b0001;
  localparam bit [3:0] TAPS = 4'b0011;

  typedef struct {
    logic [W-1:0] q;
    logic         wrap;
    logic         lock;
    string        name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   checks;
  int   errors;

  int m_q;
  bit m_wrap;
  bit m_lock;

  shift_seq_counter_if #(.WIDTH(W)) bus ();

  shift_seq_counter #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: rotations and shifts done with integer arithmetic on the state value.
  function automatic void model_step(input bit r, input bit ld, input bit e,
                                     input bit [1:0] md, input bit d, input int lv);
    int v;
    bit stepped;
    v = m_q;
    stepped = 1'b0;
    m_wrap = 1'b0;
    m_lock = 1'b0;
    if (r) begin
      v = SEED;
    end else if (ld) begin
      v = lv;
    end else if (e) begin
      case (md)
        2'd0: begin
          v = d ? (((v << 1) & 15) | (v >> 3)) : ((v >> 1) | ((v & 1) << 3));
          stepped = 1'b1;
        end
        2'd1: begin
          v = d ? (((v << 1) & 15) | ((v >> 3) ^ 1)) : ((v >> 1) | (((v & 1) ^ 1) << 3));
          stepped = 1'b1;
        end
        2'd2: begin
          if (v == 0) begin
            v = SEED;
            m_lock = 1'b1;
          end else begin
            v = (v >> 1) | (($countones(v & TAPS) % 2) << 3);
            stepped = 1'b1;
          end
        end
        default: ;
      endcase
    end
    m_q = v;
    if (stepped && v == SEED) m_wrap = 1'b1;
  endfunction

  // One stimulus cycle; expectation is a literal when lit=1, otherwise the model's.
  task automatic cyc(input bit r, input bit ld, input bit e, input bit [1:0] md,
                     input bit d, input bit [3:0] lv, input bit lit,
                     input bit [3:0] lq, input bit lw, input bit ll, input string nm);
    exp_t x;
    @(negedge clk);
    reset        = r;
    bus.load     = ld;
    bus.en       = e;
    bus.mode     = md;
    bus.dir      = d;
    bus.load_val = lv;
    model_step(r, ld, e, md, d, int'(lv));
    x.name = nm;
    if (lit) begin
      x.q = lq; x.wrap = lw; x.lock = ll;
    end else begin
      x.q = 4'(m_q); x.wrap = m_wrap; x.lock = m_lock;
    end
    sb.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk({x.name, ".q"}, bus.q, x.q);
        chk({x.name, ".q_n"}, bus.q_n, ~x.q);
        chk({x.name, ".wrap"}, 4'(bus.wrap), 4'(x.wrap));
        chk({x.name, ".lock_err"}, 4'(bus.lock_err), 4'(x.lock));
      end
    end
  end

  initial begin : stim
    bit [3:0] ring_t[4]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    bit [3:0] john_t[8]  = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                             4'b1111, 4'b0111, 4'b0011, 4'b0001};
    bit [3:0] lfsr_t[15] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100,
                             4'b0110, 4'b1011, 4'b0101, 4'b1010, 4'b1101,
                             4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
    checks = 0;
    errors = 0;
    m_q = 0;
    reset = 1'b0;
    bus.en = 1'b0; bus.mode = 2'b00; bus.dir = 1'b0;
    bus.load = 1'b0; bus.load_val = '0;

    cyc(1, 0, 0, 0, 0, 0, 1, 4'b0001, 0, 0, "reset");
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 1, 0, 0, 0, 1, ring_t[i], i == 3, 0, $sformatf("ring%0d", i));
    cyc(0, 0, 0, 0, 0, 0, 1, 4'b0001, 0, 0, "ring_idle");

    cyc(1, 0, 0, 1, 0, 0, 1, 4'b0001, 0, 0, "reset_j");
    for (int i = 0; i < 8; i++)
      cyc(0, 0, 1, 1, 0, 0, 1, john_t[i], i == 7, 0, $sformatf("john%0d", i));

    cyc(1, 0, 0, 2, 0, 0, 1, 4'b0001, 0, 0, "reset_l");
    for (int i = 0; i < 15; i++)
      cyc(0, 0, 1, 2, 0, 0, 1, lfsr_t[i], i == 14, 0, $sformatf("lfsr%0d", i));
    cyc(0, 0, 1, 2, 0, 0, 1, 4'b1000, 0, 0, "lfsr_period");

    cyc(0, 1, 0, 2, 0, 4'b0000, 1, 4'b0000, 0, 0, "load_zero");
    cyc(0, 0, 1, 2, 0, 0, 1, 4'b0001, 0, 1, "lockup");
    cyc(0, 0, 0, 2, 0, 0, 1, 4'b0001, 0, 0, "lock_clear");

    cyc(0, 0, 1, 3, 0, 0, 1, 4'b0001, 0, 0, "hold_seed");
    cyc(0, 1, 1, 0, 0, 4'b1010, 1, 4'b1010, 0, 0, "load_over_en");
    cyc(0, 0, 1, 0, 1, 0, 1, 4'b0101, 0, 0, "ring_dir1");

    cyc(0, 0, 1, 0, 0, 0, 1, 4'b1010, 0, 0, "mid_step");
    cyc(1, 1, 1, 0, 0, 4'b1111, 1, 4'b0001, 0, 0, "reset_over_load");
    cyc(0, 0, 1, 0, 0, 0, 1, 4'b1000, 0, 0, "after_reset");

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rnd_reset");
    for (int i = 0; i < 400; i++) begin
      bit r, ld, e, d;
      bit [1:0] md;
      bit [3:0] lv;
      r  = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 9) < 7);
      md = 2'($urandom_range(0, 3));
      d  = 1'($urandom_range(0, 1));
      lv = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      cyc(r, ld, e, md, d, lv, 0, 0, 0, 0, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    bus.en = 1'b0; bus.load = 1'b0; reset = 1'b0;
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_seq_counter.md
SHIFT_SEQ_COUNTER -- requirements
Module: shift_seq_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 SHALL have parameter SEED, default {WIDTH-1 zeros, 1}: reset/recovery state; must be non-zero.
REQ-003 SHALL have parameter TAPS, default 4'b0011 (WIDTH bits): LFSR feedback mask; TAPS[0] must be 1.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1: advance one step when high.
REQ-007 SHALL have port mode, input, 2: 00 ring, 01 Johnson, 10 LFSR, 11 hold.
REQ-008 SHALL have port dir, input, 1: 0 shift toward LSB, 1 shift toward MSB; ignored in LFSR and hold modes.
REQ-009 SHALL have port load, input, 1: parallel-load request.
REQ-010 SHALL have port load_val, input, WIDTH: value written on load.
REQ-011 SHALL have port q, output, WIDTH: current state (registered).
REQ-012 SHALL have port q_n, output, WIDTH: bitwise complement of q at all times.
REQ-013 SHALL have port wrap, output, 1: registered one-cycle pulse marking sequence wrap to SEED.
REQ-014 SHALL have port lock_err, output, 1: registered one-cycle pulse marking LFSR lock-up recovery.

Function
REQ-015 SHALL apply per-edge priority: reset > load > en > hold.
REQ-016 SHALL, on load, set q=load_val regardless of mode or en, with wrap=0 and lock_err=0 next cycle.
REQ-017 SHALL, in ring mode with dir=0, compute next q = {q[0], q[WIDTH-1:1]}; with dir=1, next q = {q[WIDTH-2:0], q[WIDTH-1]}.
REQ-018 SHALL, in Johnson mode with dir=0, compute next q = {~q[0], q[WIDTH-1:1]}; with dir=1, next q = {q[WIDTH-2:0], ~q[WIDTH-1]}.
REQ-019 SHALL, in LFSR mode, compute fb = XOR-reduce(q & TAPS) and next q = {fb, q[WIDTH-1:1]}.
REQ-020 SHALL, in hold mode, keep q unchanged even when en=1; wrap and lock_err are 0.
REQ-021 SHALL, in LFSR mode with en=1 and q all-zero, load q=SEED instead of stepping and assert lock_err for exactly the next cycle.
REQ-022 SHALL assert wrap for one cycle following any en-driven step (not load, reset or lock-up recovery) whose new q equals SEED.
REQ-023 SHALL apply a mode or dir change on the first enabled step after the change, with no reset of q.
REQ-024 SHALL not detect or correct non-one-hot states in ring mode or illegal states in Johnson mode; these states simply rotate.
REQ-025 SHALL have a latency of one clock from en/load/reset sampled high to the updated q.

Reset
REQ-026 SHALL, on reset high at a rising edge, set q=SEED, q_n=~SEED, wrap=0 and lock_err=0, overriding load and en.
REQ-027 SHALL, on reset asserted mid-sequence, return to SEED on that edge and resume stepping from SEED on the first edge after release.

Verification
REQ-028 SHALL pass this case: reset, then ring, dir=0, en=1 for 4 cycles -> q = 1000, 0100, 0010, 0001, with wrap=1 only in the cycle after q returns to 0001.
REQ-029 SHALL pass this case: reset, then Johnson, dir=0, en=1 for 8 cycles -> q = 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, with wrap after the 8th step.
REQ-030 SHALL pass this case: reset, then LFSR, en=1 -> q = 1000, 0100, 0010, 1001, 1100, 0110, 1011, 0101, 1010, 1101, 1110, 1111, 0111, 0011, 0001, with period 15 and wrap after the 15th step.
REQ-031 SHALL pass this case: LFSR, load 0000, then en=1 -> q = 0001, lock_err=1 for one cycle, wrap=0.
REQ-032 SHALL pass this case: load=1 and en=1 together with load_val=1010 -> q = 1010 with no step, then ring dir=1 step -> 0101.
REQ-033 SHALL pass this case: reset=1 with load=1 and en=1 mid-sequence -> q = 0001, both outputs 0, and after release the next ring step gives 1000.
